regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 64-bit, 32-entry register-file read port between NREQ requesters.
- The read port is the existing 32:1 by 64-bit mux. This block drives the mux select, captures the mux output and returns tagged responses.
- Fully pipelined: one grant per cycle, fixed 2-cycle response latency. Used where fetch/decode/debug-style clients contend for a single read port.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must equal ceil(log2(NREQ))
WIDTH, 64, data width
ZERO_REG, 1, when 1 a read of address 31 returns all zeros regardless of rd_data

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
stall  input  1  when 1, no new grants; in-flight reads still complete
req_valid  input  NREQ  per-requester read request
req_addr  input  5*NREQ  flattened addresses; requester i at bits [5i+4:5i]
req_ready  output  NREQ  one-hot grant (combinational); request accepted at the edge where valid and ready are both 1
rd_sel  output  5  select to the shared read mux (registered)
rd_data  input  WIDTH  shared mux output; combinational from rd_sel
resp_valid  output  1  response valid, one-cycle pulse per accepted request
resp_id  output  IDW  requester index of the response
resp_data  output  WIDTH  read data

Behaviour:
- Reset values (async): ptr=0, s1_valid=0, s1_id=0, s1_addr=0, rd_sel=0, resp_valid=0, resp_id=0, resp_data=0.
- Grant logic (combinational):
  - If stall=1 or req_valid=0, req_ready=0.
  - Otherwise search indices ptr, ptr+1, ... mod NREQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0.
  - At most one bit of req_ready is ever set.
  - req_ready never depends on req_addr.
- Accept edge (grant g issued in cycle N):
  - s1_valid<=1, s1_id<=g, s1_addr<=req_addr[g].
  - ptr<=(g+1) mod NREQ.
- No-grant edge: s1_valid<=0; s1_addr and ptr hold.
- rd_sel equals s1_addr at all times. It holds its last value when idle, so the mux does not toggle.
- Stage 2 edge (end of cycle N+1):
  - resp_valid<=s1_valid, resp_id<=s1_id.
  - If s1_valid=1: resp_data<=0 when ZERO_REG=1 and s1_addr=31, else rd_data. If s1_valid=0, resp_data holds.
- Latency: request granted in cycle N yields resp_valid=1 in cycle N+2.
- Throughput: one grant per cycle. Back-to-back grants produce back-to-back responses in grant order.
- No response backpressure: every requester must accept a response in the cycle resp_valid is high.
- A requester that keeps req_valid high is re-granted only after every other valid requester has been granted once (round-robin fairness). Worst-case wait is NREQ-1 cycles when stall=0.
- stall=1: req_ready=0 and ptr holds. Stage-1 content advances to stage 2 normally, so an in-flight read still responds.
- stall deassert: arbitration resumes from the held ptr in the same cycle.
- Requester dropping req_valid while not granted: no effect; arbitration is purely per-cycle, with no lock or reservation.
- Reset mid-operation: in-flight reads are discarded, and no resp_valid is produced for them after reset deasserts. First grant after reset goes to the lowest valid index.
- NREQ not a power of 2: ptr wraps from NREQ-1 to 0. IDs >= NREQ never appear on resp_id.

Test Plan:
- Single read: only req_valid[2]=1, addr=5, rd_data model returns 64'h5555 for sel 5 -> req_ready=4'b0100 in cycle N; rd_sel=5 in N+1; resp_valid=1, resp_id=2, resp_data=64'h5555 in N+2.
- Four-way contention: all four valid from reset with addrs 1,2,3,4, each dropped after its grant -> grants 0,1,2,3 in consecutive cycles; responses with IDs 0,1,2,3 in cycles N+2..N+5; rd_sel sequence 1,2,3,4.
- Fairness: req 1 and req 3 held valid for 8 cycles -> grants alternate 1,3,1,3,...; no requester is granted twice in a row.
- Zero register: ZERO_REG=1, addr=31 with rd_data=64'hFFFF420 -> resp_data=0. Same test with ZERO_REG=0 -> resp_data=64'hFFFF420.
- Stall: grant req 0 in cycle N, stall=1 for cycles N+1..N+3 with req 1 valid -> response ID 0 in N+2; req_ready=0 during stall; req 1 granted in N+4.
- Reset mid-flight: grant in cycle N, reset pulse in N+1 -> resp_valid stays 0 through N+3; all outputs at reset values; next grant goes to the lowest valid index.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
//   Shares one 32-entry register-file read port between NREQ requesters.
//   A round-robin grant is issued each cycle. The granted address drives the
//   shared mux select (rd_sel) for one cycle. The mux output is then captured
//   and returned as a tagged response, two cycles after the grant.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   stall      blocks new grants; reads already in flight still complete
//   req_valid  per-requester read request
//   req_addr   flattened 5-bit addresses, requester i at [5i+4:5i]
//   req_ready  one-hot grant (combinational)
//   rd_sel     registered select to the shared read mux
//   rd_data    shared mux output, combinational from rd_sel
//   resp_valid one-cycle pulse per accepted request
//   resp_id    requester index of the response
//   resp_data  read data (zero for address 31 when ZERO_REG=1)
module regfile_read_arbiter #(
   parameter int NREQ     = 4,
   parameter int IDW      = 2,
   parameter int WIDTH    = 64,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [5*NREQ-1:0]    req_addr,
   output logic [NREQ-1:0]      req_ready,
   output logic [4:0]           rd_sel,
   input  logic [WIDTH-1:0]     rd_data,
   output logic                 resp_valid,
   output logic [IDW-1:0]       resp_id,
   output logic [WIDTH-1:0]     resp_data
);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             s1_valid_q;
   logic [IDW-1:0]   s1_id_q;
   logic [4:0]       s1_addr_q;
   logic             resp_valid_q;
   logic [IDW-1:0]   resp_id_q;
   logic [WIDTH-1:0] resp_data_q;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_id;
   logic [4:0]       gnt_addr;

   // Rotating priority search starting at ptr_q; the first valid requester wins.
   always_comb begin
      int idx;
      req_ready = '0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      gnt_addr  = '0;
      idx       = 0;
      if (!stall) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid[idx]) begin
               gnt_found      = 1'b1;
               req_ready[idx] = 1'b1;
               gnt_id         = IDW'(idx);
               gnt_addr       = req_addr[5*idx +: 5];
            end
         end
      end
   end

   // Pointer moves just past the winner so it becomes lowest priority next cycle.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_found) begin
         if (int'(gnt_id) == NREQ - 1) ptr_d = '0;
         else                         ptr_d = gnt_id + IDW'(1);
      end
   end

   // Stage 1: capture the grant; address holds when idle so the mux stays quiet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_addr_q  <= '0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= gnt_found;
         if (gnt_found) begin
            s1_id_q   <= gnt_id;
            s1_addr_q <= gnt_addr;
         end
      end
   end

   assign rd_sel = s1_addr_q;

   // Stage 2: capture the mux output; data holds when no read is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
      end else begin
         resp_valid_q <= s1_valid_q;
         resp_id_q    <= s1_id_q;
         if (s1_valid_q) begin
            if (ZERO_REG != 0 && s1_addr_q == 5'd31) resp_data_q <= '0;
            else                                     resp_data_q <= rd_data;
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
module tb_regfile_read_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int W    = 64;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              stall = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [5*NREQ-1:0] req_addr = '0;

   logic [NREQ-1:0]   req_ready, req_ready0;
   logic [4:0]        rd_sel, rd_sel0;
   logic [W-1:0]      rd_data, rd_data0;
   logic              resp_valid, resp_valid0;
   logic [IDW-1:0]    resp_id, resp_id0;
   logic [W-1:0]      resp_data, resp_data0;

   logic [W-1:0]      mem [32];

   assign rd_data  = mem[rd_sel];
   assign rd_data0 = mem[rd_sel0];

   regfile_read_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(W), .ZERO_REG(1)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .rd_sel(rd_sel), .rd_data(rd_data),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data));

   regfile_read_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(W), .ZERO_REG(0)) u_dut0 (
      .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready0), .rd_sel(rd_sel0), .rd_data(rd_data0),
      .resp_valid(resp_valid0), .resp_id(resp_id0), .resp_data(resp_data0));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: round-robin pointer plus a queue of outstanding reads
   // tagged with the edge at which their response must appear.
   typedef struct {
      int         due;
      int         id;
      logic [4:0] addr;
   } rsp_t;

   rsp_t            q[$];
   int              ptr = 0;
   int              edges = 0;
   logic [4:0]      last_sel = '0;
   logic [W-1:0]    last_data = '0;
   logic [W-1:0]    last_data0 = '0;
   int              last_g = -1;
   logic [NREQ-1:0] obs_ready = '0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      if (stall) return -1;
      for (int k = 0; k < NREQ; k++)
         if (req_valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [W-1:0] model_data(input logic [4:0] a, input bit zero_reg);
      if (zero_reg && a == 5'd31) return '0;
      return mem[a];
   endfunction

   // One clock cycle: inputs must already be set (just after the previous edge).
   task automatic step();
      int g;
      logic [NREQ-1:0] exp_ready;
      @(negedge clk);
      g = model_grant();
      exp_ready = (g >= 0) ? NREQ'(1) << g : '0;
      obs_ready = req_ready;
      chk("req_ready", req_ready, exp_ready);
      chk("req_ready_z0", req_ready0, exp_ready);
      @(posedge clk);
      edges++;
      if (g >= 0) begin
         q.push_back('{due: edges + 1, id: g, addr: req_addr[5*g +: 5]});
         ptr = (g + 1) % NREQ;
         last_sel = req_addr[5*g +: 5];
      end
      last_g = g;
      #1;
      chk("rd_sel", rd_sel, last_sel);
      if (q.size() > 0 && q[0].due == edges) begin
         last_data  = model_data(q[0].addr, 1'b1);
         last_data0 = model_data(q[0].addr, 1'b0);
         chk("resp_valid", resp_valid, 1);
         chk("resp_id", resp_id, q[0].id);
         chk("resp_valid_z0", resp_valid0, 1);
         chk("resp_data_z0", resp_data0, last_data0);
         void'(q.pop_front());
      end else begin
         chk("resp_valid", resp_valid, 0);
         chk("resp_valid_z0", resp_valid0, 0);
      end
      chk("resp_data", resp_data, last_data);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_id"}, resp_id, 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_rd_sel"}, rd_sel, 0);
      chk({tag, "_resp_data_z0"}, resp_data0, 0);
   endtask

   // Called just after an edge; leaves the bench just after an edge with reset low.
   task automatic pulse_reset();
      reset = 1'b1;
      q.delete();
      ptr = 0;
      last_sel = '0;
      last_data = '0;
      last_data0 = '0;
      #2;
      check_reset_state("rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = {$urandom, $urandom};
      mem[5]  = 64'h5555;
      mem[31] = 64'hFFFF420;

      // Reset state
      #12;
      check_reset_state("por");
      chk("por_ready", req_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single read from requester 2
      req_valid = 4'b0100;
      req_addr[10 +: 5] = 5'd5;
      step();
      chk("single_grant", obs_ready, 4'b0100);
      req_valid = '0;
      step();
      step();
      chk("single_data", resp_data, 64'h5555);
      step();

      // Four-way contention from reset, each dropped after its grant
      pulse_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < NREQ; i++) req_addr[5*i +: 5] = 5'(i + 1);
      for (int i = 0; i < NREQ; i++) begin
         step();
         chk("four_way_order", obs_ready, 4'b0001 << i);
         if (last_g >= 0) req_valid[last_g] = 1'b0;
      end
      repeat (3) step();

      // Fairness between 1 and 3
      req_valid = 4'b1010;
      req_addr[5 +: 5] = 5'd7;
      req_addr[15 +: 5] = 5'd9;
      step();
      for (int i = 0; i < 7; i++) begin
         logic [NREQ-1:0] prev;
         prev = obs_ready;
         step();
         chk("fair_alternate", obs_ready, (prev == 4'b0010) ? 4'b1000 : 4'b0010);
      end
      req_valid = '0;
      repeat (2) step();

      // Zero register
      req_valid = 4'b0001;
      req_addr[0 +: 5] = 5'd31;
      step();
      req_valid = '0;
      step();
      step();
      chk("zero_reg1", resp_data, 64'h0);
      chk("zero_reg0", resp_data0, 64'hFFFF420);

      // Stall with an in-flight read
      req_valid = 4'b0001;
      req_addr[0 +: 5] = 5'd3;
      req_addr[5 +: 5] = 5'd4;
      step();
      req_valid = 4'b0010;
      stall = 1'b1;
      step();
      chk("stall_ready", obs_ready, 0);
      step();
      chk("stall_resp_id", resp_id, 0);
      step();
      stall = 1'b0;
      step();
      chk("stall_resume", obs_ready, 4'b0010);
      req_valid = '0;
      repeat (3) step();

      // Reset mid-flight
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      pulse_reset();
      step();
      chk("midrst_no_resp", resp_valid, 0);
      step();
      req_valid = 4'b1100;
      step();
      chk("midrst_lowest", obs_ready, 4'b0100);
      req_valid = '0;
      repeat (3) step();

      // Randomised traffic
      for (int n = 0; n < 300; n++) begin
         req_valid = NREQ'($urandom);
         req_addr  = (5*NREQ)'($urandom);
         stall     = ($urandom_range(0, 7) == 0);
         step();
      end
      req_valid = '0;
      stall = 1'b0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
